ab_index_sched: RTL

Controller that owns the single read port of the sequence-A memory and sequences it between the matrix-fill phase and the traceback phase of the NW engine. It generates the fill row index itself, then serves traceback index requests until traceback ends. Exactly one read is outstanding at a time. Index 0 is the guard row and never reaches the memory.

---
 rtl/ab_index_sched.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/ab_index_sched.sv
// Read-port scheduler for the sequence-A memory: fill-phase row indices, then traceback requests.
// Optional read counter enabled by defining AB_SCHED_PERF_EN; otherwise o_rd_count is tied to 0.
module ab_index_sched #(
   parameter int N       = 128,
   parameter int BitAddr = $clog2(N + 1),
   parameter int W       = 2
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic               i_row_req,
   input  logic               i_tb_start,
   input  logic               i_tb_req,
   input  logic [BitAddr:0]   i_i_t,
   input  logic               i_tb_end,
   output logic               o_ready,
   output logic [BitAddr:0]   o_i,
   output logic               o_mem_en,
   output logic [BitAddr:0]   o_mem_addr,
   input  logic [W-1:0]       i_mem_rdata,
   output logic [W-1:0]       o_a_char,
   output logic               o_a_valid,
   output logic               o_fill_done,
   output logic               o_done,
   output logic [15:0]        o_rd_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FILL    = 3'd1,
      S_WAIT_TB = 3'd2,
      S_TRACE   = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam logic [BitAddr:0] L_N   = (BitAddr + 1)'(N);
   localparam logic [BitAddr:0] L_ONE = (BitAddr + 1)'(1);

   state_t              r_state;
   state_t              w_state_next;
   logic [BitAddr:0]    r_i;
   logic                r_pend;
   logic                r_mem_en;
   logic [BitAddr:0]    r_mem_addr;
   logic                r_s1_vld;
   logic                r_s1_zero;
   logic                r_s2_vld;
   logic                r_s2_zero;
   logic                r_a_valid;
   logic [W-1:0]        r_a_char;
   logic                r_fill_done;

   logic                w_can_issue;
   logic                w_ready;
   logic                w_accept_row;
   logic                w_accept_tb;
   logic                w_load_i;
   logic                w_clr_i;
   logic                w_idx_ok;
   logic                w_mem_issue;
   logic                w_fire;

   // The slot frees up on the cycle the result is about to be registered,
   // giving one accepted request every two cycles.
   assign w_can_issue = !r_pend || r_s2_vld;
   assign w_idx_ok    = (i_i_t != '0) && (i_i_t <= L_N);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      w_accept_row = 1'b0;
      w_accept_tb  = 1'b0;
      w_load_i     = 1'b0;
      w_clr_i      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_next = S_FILL;
               w_load_i     = 1'b1;
            end
         end
         S_FILL: begin
            w_ready = w_can_issue;
            if (i_row_req && w_can_issue) begin
               w_accept_row = 1'b1;
               if (r_i == L_N) w_state_next = S_WAIT_TB;
            end
         end
         S_WAIT_TB: begin
            if (i_tb_start) w_state_next = S_TRACE;
         end
         S_TRACE: begin
            w_ready = w_can_issue;
            if (i_tb_end)                       w_state_next = S_DONE;
            else if (i_tb_req && w_can_issue)   w_accept_tb  = 1'b1;
         end
         S_DONE: begin
            w_state_next = S_IDLE;
            w_clr_i      = 1'b1;
         end
         default: begin
            w_state_next = S_IDLE;
            w_clr_i      = 1'b1;
         end
      endcase
      if (i_abort) begin
         w_state_next = S_IDLE;
         w_ready      = 1'b0;
         w_accept_row = 1'b0;
         w_accept_tb  = 1'b0;
         w_load_i     = 1'b0;
         w_clr_i      = 1'b1;
      end
   end

   assign w_mem_issue = w_accept_row || (w_accept_tb && w_idx_ok);
   assign w_fire      = r_s2_vld && !i_abort;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_i <= '0;
      end else if (w_clr_i) begin
         r_i <= '0;
      end else if (w_load_i) begin
         r_i <= L_ONE;
      end else if (w_accept_row && (r_i != L_N)) begin
         r_i <= r_i + L_ONE;
      end
   end

   // Guard-row and out-of-range traceback indices travel down the pipeline as
   // "zero" requests so the reply keeps the same latency without touching memory.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mem_en    <= 1'b0;
         r_mem_addr  <= '0;
         r_s1_vld    <= 1'b0;
         r_s1_zero   <= 1'b0;
         r_s2_vld    <= 1'b0;
         r_s2_zero   <= 1'b0;
         r_fill_done <= 1'b0;
      end else begin
         r_mem_en    <= w_mem_issue;
         r_s1_vld    <= w_accept_row || w_accept_tb;
         r_s1_zero   <= w_accept_tb && !w_idx_ok;
         r_s2_vld    <= r_s1_vld && !i_abort;
         r_s2_zero   <= r_s1_zero;
         r_fill_done <= w_accept_row && (r_i == L_N);
         if (w_accept_row)                  r_mem_addr <= r_i;
         else if (w_accept_tb && w_idx_ok)  r_mem_addr <= i_i_t;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pend    <= 1'b0;
         r_a_valid <= 1'b0;
         r_a_char  <= '0;
      end else begin
         r_a_valid <= w_fire;
         if (w_fire) r_a_char <= r_s2_zero ? '0 : i_mem_rdata;
         if (i_abort)                         r_pend <= 1'b0;
         else if (w_accept_row || w_accept_tb) r_pend <= 1'b1;
         else if (r_s2_vld)                    r_pend <= 1'b0;
      end
   end

`ifdef AB_SCHED_PERF_EN
   logic [15:0] r_rd_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rd_count <= '0;
      end else if (w_load_i) begin
         r_rd_count <= '0;
      end else if (r_mem_en && (r_rd_count != 16'hFFFF)) begin
         r_rd_count <= r_rd_count + 16'd1;
      end
   end

   assign o_rd_count = r_rd_count;
`else
   assign o_rd_count = 16'd0;
`endif

   assign o_ready     = w_ready;
   assign o_i         = r_i;
   assign o_mem_en    = r_mem_en;
   assign o_mem_addr  = r_mem_addr;
   assign o_a_char    = r_a_char;
   assign o_a_valid   = r_a_valid;
   assign o_fill_done = r_fill_done;
   assign o_done      = (r_state == S_DONE);

endmodule
